// File: rtl/toy_pack.sv
// Shared sizing and entry-state encoding for the instruction-cache MSHR allocator.
package toy_pack;
   localparam int MSHR_ENTRY_NUM         = 8;
   localparam int MSHR_ENTRY_INDEX_WIDTH = $clog2(MSHR_ENTRY_NUM);

   typedef enum logic [1:0] {
      ENTRY_FREE      = 2'd0,
      ENTRY_LOOKUP    = 2'd1,
      ENTRY_MISS_WAIT = 2'd2
   } entry_state_e;
endpackage

// File: rtl/icache_mshr_alloc_if.sv
// Allocation offer, lookup/refill completions, flush and status of the MSHR allocator.
interface icache_mshr_alloc_if
   import toy_pack::*;
#(
   parameter int IW = MSHR_ENTRY_INDEX_WIDTH
);
   logic          alloc_vld;
   logic [IW-1:0] alloc_index;
   logic          alloc_rdy;
   logic          lookup_resp_vld;
   logic [IW-1:0] lookup_resp_index;
   logic          lookup_resp_hit;
   logic          refill_done_vld;
   logic [IW-1:0] refill_done_index;
   logic          flush;
   logic [IW:0]   free_cnt;
   logic          proto_err;

   modport master (
      input  alloc_vld, alloc_index, free_cnt, proto_err,
      output alloc_rdy, lookup_resp_vld, lookup_resp_index, lookup_resp_hit,
             refill_done_vld, refill_done_index, flush
   );

   modport slave (
      output alloc_vld, alloc_index, free_cnt, proto_err,
      input  alloc_rdy, lookup_resp_vld, lookup_resp_index, lookup_resp_hit,
             refill_done_vld, refill_done_index, flush
   );
endinterface

// File: rtl/icache_mshr_find_first.sv
// Priority encoder: lowest set bit of req as onehot and binary index, plus any-set flag.
module icache_mshr_find_first #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] index,
   output logic          any
);
   assign onehot = req & (~req + N'(1));
   assign any    = |req;

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) index = IW'(i);
      end
   end
endmodule

// File: rtl/icache_mshr_alloc.sv
// MSHR entry allocator: offers the lowest FREE entry and tracks FREE/LOOKUP/MISS_WAIT per entry.
module icache_mshr_alloc
   import toy_pack::*;
#(
   parameter int MSHR_ENTRY_NUM         = toy_pack::MSHR_ENTRY_NUM,
   parameter int MSHR_ENTRY_INDEX_WIDTH = $clog2(MSHR_ENTRY_NUM)
) (
   input  logic                clk,
   input  logic                rst_n,
   icache_mshr_alloc_if.slave  bus
);
   localparam int IW = MSHR_ENTRY_INDEX_WIDTH;
   localparam int CW = MSHR_ENTRY_INDEX_WIDTH + 1;

   logic [MSHR_ENTRY_NUM-1:0] free_vec;
   logic [MSHR_ENTRY_NUM-1:0] free_next_vec;
   logic [MSHR_ENTRY_NUM-1:0] lookup_pend_vec;
   logic [MSHR_ENTRY_NUM-1:0] miss_pend_vec;
   logic [MSHR_ENTRY_NUM-1:0] lookup_sel_vec;
   logic [MSHR_ENTRY_NUM-1:0] refill_sel_vec;
   logic [MSHR_ENTRY_NUM-1:0] alloc_onehot;
   logic [IW-1:0]             first_index;
   logic                      first_any;
   logic                      alloc_fire;
   logic                      lookup_err;
   logic                      refill_err;
   logic [CW-1:0]             free_cnt_reg;
   logic [CW-1:0]             free_cnt_next;
   logic                      proto_err_reg;

   icache_mshr_find_first #(
      .N  (MSHR_ENTRY_NUM),
      .IW (IW)
   ) u_find_first (
      .req    (free_vec),
      .onehot (alloc_onehot),
      .index  (first_index),
      .any    (first_any)
   );

   assign bus.alloc_vld   = first_any;
   assign bus.alloc_index = first_index;
   assign alloc_fire      = first_any & bus.alloc_rdy;

   generate
      for (genvar gi = 0; gi < MSHR_ENTRY_NUM; gi++) begin : g_entry
         entry_state_e state_reg;
         entry_state_e state_next;

         // Out-of-range indices never match any entry, so they surface as errors below.
         assign lookup_sel_vec[gi] = bus.lookup_resp_vld && (bus.lookup_resp_index == IW'(gi));
         assign refill_sel_vec[gi] = bus.refill_done_vld && (bus.refill_done_index == IW'(gi));

         always_comb begin
            state_next = state_reg;
            if (bus.flush) begin
               state_next = ENTRY_FREE;
            end else begin
               case (state_reg)
                  ENTRY_FREE:
                     if (alloc_fire && alloc_onehot[gi]) state_next = ENTRY_LOOKUP;
                  ENTRY_LOOKUP:
                     if (lookup_sel_vec[gi])
                        state_next = bus.lookup_resp_hit ? ENTRY_FREE : ENTRY_MISS_WAIT;
                  ENTRY_MISS_WAIT:
                     if (refill_sel_vec[gi]) state_next = ENTRY_FREE;
                  default:
                     state_next = ENTRY_FREE;
               endcase
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_reg <= ENTRY_FREE;
            else        state_reg <= state_next;
         end

         assign free_vec[gi]        = (state_reg  == ENTRY_FREE);
         assign free_next_vec[gi]   = (state_next == ENTRY_FREE);
         assign lookup_pend_vec[gi] = (state_reg  == ENTRY_LOOKUP);
         assign miss_pend_vec[gi]   = (state_reg  == ENTRY_MISS_WAIT);
      end
   endgenerate

   assign lookup_err = bus.lookup_resp_vld && ((lookup_sel_vec & lookup_pend_vec) == '0);
   assign refill_err = bus.refill_done_vld && ((refill_sel_vec & miss_pend_vec) == '0);

   always_comb begin
      free_cnt_next = '0;
      for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
         free_cnt_next = free_cnt_next + CW'(free_next_vec[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_cnt_reg  <= CW'(MSHR_ENTRY_NUM);
         proto_err_reg <= 1'b0;
      end else begin
         free_cnt_reg  <= free_cnt_next;
         proto_err_reg <= proto_err_reg | lookup_err | refill_err;
      end
   end

   assign bus.free_cnt  = free_cnt_reg;
   assign bus.proto_err = proto_err_reg;
endmodule

// File: tb/tb_icache_mshr_alloc.sv
// Bench for icache_mshr_alloc: directed scenarios with literal expectations, then randomized traffic vs an entry-table model.
module tb_icache_mshr_alloc;
   import toy_pack::*;

   localparam int N  = 8;
   localparam int IW = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   icache_mshr_alloc_if #(.IW(IW)) bus();

   icache_mshr_alloc #(
      .MSHR_ENTRY_NUM         (N),
      .MSHR_ENTRY_INDEX_WIDTH (IW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Model entry table: 0 = free, 1 = waiting for lookup, 2 = waiting for refill.
   int mdl[N];
   bit mdl_err;
   bit chk_en = 1'b0;
   int errors = 0;
   int checks = 0;

   function automatic int m_cnt();
      int c = 0;
      foreach (mdl[i]) if (mdl[i] == 0) c++;
      return c;
   endfunction

   function automatic int m_first();
      foreach (mdl[i]) if (mdl[i] == 0) return i;
      return N;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (mdl[i]) mdl[i] = 0;
      mdl_err = 1'b0;
   endtask

   task automatic idle();
      bus.alloc_rdy         = 1'b0;
      bus.lookup_resp_vld   = 1'b0;
      bus.lookup_resp_index = '0;
      bus.lookup_resp_hit   = 1'b0;
      bus.refill_done_vld   = 1'b0;
      bus.refill_done_index = '0;
      bus.flush             = 1'b0;
   endtask

   // Apply the currently driven inputs for one clock and advance the model.
   task automatic cycle();
      int nxt[N];
      int f, li, ri;
      bit err;
      nxt = mdl;
      f   = m_first();
      li  = int'(bus.lookup_resp_index);
      ri  = int'(bus.refill_done_index);
      err = mdl_err;
      if (bus.lookup_resp_vld && (li >= N || mdl[li] != 1)) err = 1'b1;
      if (bus.refill_done_vld && (ri >= N || mdl[ri] != 2)) err = 1'b1;
      if (bus.flush) begin
         foreach (nxt[i]) nxt[i] = 0;
      end else begin
         if (bus.alloc_rdy && f < N) nxt[f] = 1;
         if (bus.lookup_resp_vld && li < N && mdl[li] == 1) nxt[li] = bus.lookup_resp_hit ? 0 : 2;
         if (bus.refill_done_vld && ri < N && mdl[ri] == 2) nxt[ri] = 0;
      end
      @(posedge clk);
      #1;
      mdl     = nxt;
      mdl_err = err;
   endtask

   // Every cycle out of reset, outputs must follow the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("alloc_vld", 32'(bus.alloc_vld), 32'(m_cnt() != 0));
         if (m_cnt() != 0) check("alloc_index", 32'(bus.alloc_index), 32'(m_first()));
         check("free_cnt", 32'(bus.free_cnt), 32'(m_cnt()));
         check("proto_err", 32'(bus.proto_err), 32'(mdl_err));
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_alloc_vld"}, 32'(bus.alloc_vld), 32'd1);
      check({tag, "_alloc_index"}, 32'(bus.alloc_index), 32'd0);
      check({tag, "_free_cnt"}, 32'(bus.free_cnt), 32'd8);
      check({tag, "_proto_err"}, 32'(bus.proto_err), 32'd0);
   endtask

   // Drop reset between clock edges, hold it across an edge with an alloc pending, then release.
   task automatic async_reset();
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_reset_vals("async_rst");
      bus.alloc_rdy = 1'b1;
      @(posedge clk);
      #1;
      check("rst_cycle_free_cnt", 32'(bus.free_cnt), 32'd8);
      @(negedge clk);
      #2;
      idle();
      rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      $display("reset: async reset released");
   endtask

   task automatic rand_stim();
      int lk[$];
      int mw[$];
      idle();
      foreach (mdl[i]) begin
         if (mdl[i] == 1) lk.push_back(i);
         else if (mdl[i] == 2) mw.push_back(i);
      end
      bus.alloc_rdy = 1'($urandom_range(0, 1));
      bus.flush     = ($urandom_range(0, 39) == 0);
      if (!bus.flush) begin
         if (lk.size() > 0 && $urandom_range(0, 1) == 1) begin
            bus.lookup_resp_vld   = 1'b1;
            bus.lookup_resp_index = IW'(lk[$urandom_range(0, lk.size() - 1)]);
            bus.lookup_resp_hit   = 1'($urandom_range(0, 1));
         end else if ($urandom_range(0, 60) == 0) begin
            bus.lookup_resp_vld   = 1'b1;
            bus.lookup_resp_index = IW'($urandom_range(0, N - 1));
            bus.lookup_resp_hit   = 1'($urandom_range(0, 1));
         end
         if (mw.size() > 0 && $urandom_range(0, 1) == 1) begin
            bus.refill_done_vld   = 1'b1;
            bus.refill_done_index = IW'(mw[$urandom_range(0, mw.size() - 1)]);
         end else if ($urandom_range(0, 60) == 0) begin
            bus.refill_done_vld   = 1'b1;
            bus.refill_done_index = IW'($urandom_range(0, N - 1));
         end
      end
   endtask

   initial begin
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      @(negedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;

      // Fill all entries in index order.
      for (int i = 0; i < N; i++) begin
         bus.alloc_rdy = 1'b1;
         check("fill_vld", 32'(bus.alloc_vld), 32'd1);
         check("fill_index", 32'(bus.alloc_index), 32'(i));
         cycle();
         $display("alloc: granted index %0d", i);
      end
      idle();
      check("full_vld", 32'(bus.alloc_vld), 32'd0);
      check("full_free_cnt", 32'(bus.free_cnt), 32'd0);
      bus.alloc_rdy = 1'b1;
      cycle();
      idle();
      check("ignored_rdy_free_cnt", 32'(bus.free_cnt), 32'd0);

      // Lookup hit frees entry 3.
      bus.lookup_resp_vld = 1'b1; bus.lookup_resp_index = 3'd3; bus.lookup_resp_hit = 1'b1;
      cycle();
      idle();
      $display("lookup: index 3 hit");
      check("hit3_vld", 32'(bus.alloc_vld), 32'd1);
      check("hit3_index", 32'(bus.alloc_index), 32'd3);
      check("hit3_free_cnt", 32'(bus.free_cnt), 32'd1);

      // Miss, refill, then a stray second refill.
      bus.lookup_resp_vld = 1'b1; bus.lookup_resp_index = 3'd2; bus.lookup_resp_hit = 1'b0;
      cycle();
      idle();
      $display("lookup: index 2 miss");
      check("miss2_free_cnt", 32'(bus.free_cnt), 32'd1);
      bus.refill_done_vld = 1'b1; bus.refill_done_index = 3'd2;
      cycle();
      idle();
      $display("refill: index 2");
      check("refill2_free_cnt", 32'(bus.free_cnt), 32'd2);
      check("refill2_index", 32'(bus.alloc_index), 32'd2);
      check("refill2_err", 32'(bus.proto_err), 32'd0);
      bus.refill_done_vld = 1'b1; bus.refill_done_index = 3'd2;
      cycle();
      idle();
      $display("refill: index 2 again (violation)");
      check("dup_refill_err", 32'(bus.proto_err), 32'd1);
      check("dup_refill_free_cnt", 32'(bus.free_cnt), 32'd2);

      // Set up entry 0 FREE, 1 LOOKUP, 4 MISS_WAIT, then three events in one cycle.
      bus.lookup_resp_vld = 1'b1; bus.lookup_resp_index = 3'd0; bus.lookup_resp_hit = 1'b1;
      cycle();
      bus.lookup_resp_vld = 1'b1; bus.lookup_resp_index = 3'd4; bus.lookup_resp_hit = 1'b0;
      cycle();
      idle();
      check("pre3_free_cnt", 32'(bus.free_cnt), 32'd3);
      check("pre3_index", 32'(bus.alloc_index), 32'd0);
      bus.alloc_rdy       = 1'b1;
      bus.lookup_resp_vld = 1'b1; bus.lookup_resp_index = 3'd1; bus.lookup_resp_hit = 1'b1;
      bus.refill_done_vld = 1'b1; bus.refill_done_index = 3'd4;
      cycle();
      idle();
      $display("combo: alloc 0, hit 1, refill 4");
      check("combo_free_cnt", 32'(bus.free_cnt), 32'd4);
      check("combo_index", 32'(bus.alloc_index), 32'd1);

      // Five busy, then flush racing an alloc.
      bus.alloc_rdy = 1'b1;
      cycle();
      idle();
      check("busy5_free_cnt", 32'(bus.free_cnt), 32'd3);
      bus.flush = 1'b1; bus.alloc_rdy = 1'b1;
      cycle();
      idle();
      $display("flush: with alloc_rdy");
      check("flush_free_cnt", 32'(bus.free_cnt), 32'd8);
      check("flush_index", 32'(bus.alloc_index), 32'd0);
      check("flush_keeps_err", 32'(bus.proto_err), 32'd1);

      // Six busy, then asynchronous reset.
      bus.alloc_rdy = 1'b1;
      repeat (6) cycle();
      idle();
      check("busy6_free_cnt", 32'(bus.free_cnt), 32'd2);
      async_reset();

      for (int n = 0; n < 3000; n++) begin
         if (n % 600 == 599) async_reset();
         rand_stim();
         cycle();
      end
      idle();
      $display("random: 3000 cycles applied");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/icache_mshr_alloc.md
ICACHE_MSHR_ALLOC -- requirements
Module: icache_mshr_alloc

Interface
REQ-001 The module SHALL have parameter MSHR_ENTRY_NUM, default 8, the number of miss-status entries tracked.
REQ-002 The module SHALL have parameter MSHR_ENTRY_INDEX_WIDTH, default $clog2(MSHR_ENTRY_NUM) = 3, the entry index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 alloc_vld  output  1  at least one entry is FREE and an index is offered.
REQ-006 alloc_index  output  MSHR_ENTRY_INDEX_WIDTH  offered entry: lowest-numbered FREE entry.
REQ-007 alloc_rdy  input  1  consumer takes the offered index this cycle.
REQ-008 lookup_resp_vld  input  1  tag lookup result for one entry.
REQ-009 lookup_resp_index  input  MSHR_ENTRY_INDEX_WIDTH  entry the result belongs to.
REQ-010 lookup_resp_hit  input  1  1 = hit, 0 = miss.
REQ-011 refill_done_vld  input  1  refill completed for one entry.
REQ-012 refill_done_index  input  MSHR_ENTRY_INDEX_WIDTH  entry being completed.
REQ-013 flush  input  1  return every entry to FREE.
REQ-014 free_cnt  output  MSHR_ENTRY_INDEX_WIDTH+1  number of FREE entries (registered).
REQ-015 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-016 Each entry SHALL hold a 2-bit state: FREE, LOOKUP, MISS_WAIT.
REQ-017 Transition: FREE -> LOOKUP when alloc_vld && alloc_rdy and alloc_index addresses it.
REQ-018 Transition: LOOKUP -> FREE on lookup_resp_vld with hit=1; LOOKUP -> MISS_WAIT on lookup_resp_vld with hit=0.
REQ-019 Transition: MISS_WAIT -> FREE on refill_done_vld addressing it.
REQ-020 alloc_vld and alloc_index SHALL be combinational from current-cycle registered state only; an entry freed this cycle is offered no earlier than the next cycle.
REQ-021 alloc_rdy asserted while alloc_vld=0 SHALL be ignored with no state change.
REQ-022 lookup_resp and refill_done for different entries in the same cycle SHALL both take effect; alloc in the same cycle SHALL also take effect (three distinct entries by construction).
REQ-023 lookup_resp_vld addressing a non-LOOKUP entry, or refill_done_vld addressing a non-MISS_WAIT entry, SHALL cause no state change and set proto_err from the next cycle.
REQ-024 Index values >= MSHR_ENTRY_NUM on any input index SHALL be treated as a protocol violation (REQ-023).
REQ-025 flush SHALL force all entries to FREE next cycle and take priority over alloc, lookup and refill events that cycle; proto_err is not cleared by flush.
REQ-026 free_cnt SHALL equal the count of FREE entries after the update, registered, so it reflects the state one cycle after the events that caused it.
REQ-027 alloc_vld=0 exactly when free_cnt=0 (full); free_cnt=MSHR_ENTRY_NUM when empty.

Reset
REQ-028 On rst_n low all entries SHALL be FREE, free_cnt=MSHR_ENTRY_NUM, proto_err=0, alloc_vld=1, alloc_index=0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries; no event from the reset cycle takes effect.

Structure
REQ-030 MSHR_ENTRY_NUM, MSHR_ENTRY_INDEX_WIDTH and the entry-state enum SHALL live in toy_pack.
REQ-031 Lowest-free-index selection SHALL be a sub-module icache_mshr_find_first (priority encoder: vector in, onehot/index/any out).
REQ-032 Per-entry state SHALL be a generate loop of identical flops; no other sub-modules.

Verification
REQ-033 After reset, alloc_rdy=1 for 8 cycles -> indices 0..7 granted in order, alloc_vld=0 and free_cnt=0 on cycle 9.
REQ-034 Entries 0..7 in LOOKUP, lookup_resp index 3 hit=1 -> entry 3 FREE, next cycle alloc_vld=1, alloc_index=3, free_cnt=1.
REQ-035 Entry 2 LOOKUP, resp miss -> MISS_WAIT; refill_done index 2 -> FREE; refill_done index 2 again -> proto_err=1, state unchanged.
REQ-036 Same cycle: alloc of entry 0, lookup hit on entry 1, refill_done on entry 4 (MISS_WAIT) -> entry 0 LOOKUP, 1 and 4 FREE, free_cnt increments by 1 net.
REQ-037 Flush with 5 entries busy and simultaneous alloc_rdy=1 -> all FREE, free_cnt=8, alloc_index=0 next cycle.
REQ-038 rst_n pulsed low asynchronously between edges with 6 entries busy -> outputs immediately at REQ-028 values.
